sc_stream_decoder_16: RTL and testbench

- Receiving end of the serial stochastic-computing path: accepts a unipolar SC bitstream one bit per cycle and counts its ones over STREAM_LENGTH valid beats.
- Undoes the leading-zero normalisation applied to both operands at encode time by rescaling the count with the two per-operand shift amounts.
- Delivers a 16-bit binary product through a valid/ready handshake.
- Sits after the bitstream generator/AND stage of the sequential SC multiplier lane in the CGRA PE.

---
 rtl/sc_dec_pkg.sv | 30 +++
 rtl/sc_rescale.sv | 67 ++++++
 rtl/sc_stream_decoder_16.sv | 129 ++++++++++++
 tb/tb_sc_stream_decoder_16.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sc_dec_pkg.sv
// sc_dec_pkg: shared definitions for the stochastic-computing stream decoder.
//
// Contents:
//   sc_dec_state_e    - decoder FSM states (IDLE, COUNT, SCALE, OUTPUT)
//   SC_DATA_WIDTH     - operand width used at encode time
//   SC_OUT_WIDTH      - result width (2*SC_DATA_WIDTH)
//   SC_STREAM_LENGTH  - valid beats per conversion (power of two, >= 2)
//   SC_SHIFT_WIDTH    - width of each operand normalisation shift
//   SC_RESCALE_BIAS   - 2*SC_DATA_WIDTH-4, the exponent of the unscaled product
//   SC_ONES_W         - ones counter width, holds 0..SC_STREAM_LENGTH inclusive
//   SC_BEAT_W         - beat counter width, wraps to 0 on the last beat
package sc_dec_pkg;

  localparam int SC_DATA_WIDTH    = 8;
  localparam int SC_OUT_WIDTH     = 2 * SC_DATA_WIDTH;
  localparam int SC_STREAM_LENGTH = 16;
  localparam int SC_SHIFT_WIDTH   = 3;

  localparam int SC_RESCALE_BIAS  = 2 * SC_DATA_WIDTH - 4;
  localparam int SC_ONES_W        = $clog2(SC_STREAM_LENGTH) + 1;
  localparam int SC_BEAT_W        = $clog2(SC_STREAM_LENGTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_SCALE  = 2'd2,
    ST_OUTPUT = 2'd3
  } sc_dec_state_e;

endpackage

// File: rtl/sc_rescale.sv
// sc_rescale: combinational rescale of a stochastic ones count back to a
// binary product, undoing the leading-zero normalisation of both operands.
//
//   k = SC_RESCALE_BIAS - sa - sb (signed)
//   k >= 0 : result = ones << k
//   k <  0 : result = ones >> -k (truncated)
//
// Optional feature (macro SC_DEC_SATURATE_EN):
//   defined   - any shifted value >= 2^SC_OUT_WIDTH clamps to all ones
//   undefined - the shifted value is truncated to SC_OUT_WIDTH bits
//
// Ports:
//   i_ones   in  SC_ONES_W       ones count from the stream
//   i_sa     in  SC_SHIFT_WIDTH  operand a normalisation shift
//   i_sb     in  SC_SHIFT_WIDTH  operand b normalisation shift
//   o_result out SC_OUT_WIDTH    rescaled product
module sc_rescale
  import sc_dec_pkg::*;
(
  input  logic [SC_ONES_W-1:0]      i_ones,
  input  logic [SC_SHIFT_WIDTH-1:0] i_sa,
  input  logic [SC_SHIFT_WIDTH-1:0] i_sb,
  output logic [SC_OUT_WIDTH-1:0]   o_result
);

  // Wide enough for the bias and both shifts; MSB is the sign of k.
  localparam int KW = 8;

  logic [KW-1:0] w_k;
  logic [KW-1:0] w_k_neg;
  logic          w_k_is_neg;

  assign w_k        = KW'(SC_RESCALE_BIAS) - KW'(i_sa) - KW'(i_sb);
  assign w_k_is_neg = w_k[KW-1];
  assign w_k_neg    = KW'(0) - w_k;

`ifdef SC_DEC_SATURATE_EN
  // Intermediate keeps every bit a left shift can produce so overflow is seen.
  localparam int WIDE_W = SC_ONES_W + SC_RESCALE_BIAS + SC_OUT_WIDTH;

  logic [WIDE_W-1:0] w_wide;

  always_comb begin
    if (w_k_is_neg) begin
      w_wide = WIDE_W'(i_ones) >> w_k_neg;
    end else begin
      w_wide = WIDE_W'(i_ones) << w_k;
    end
    if (|w_wide[WIDE_W-1:SC_OUT_WIDTH]) begin
      o_result = '1;
    end else begin
      o_result = w_wide[SC_OUT_WIDTH-1:0];
    end
  end
`else
  // Shifting inside the output width drops overflow bits, matching the
  // combinational SC multiplier bit for bit.
  always_comb begin
    if (w_k_is_neg) begin
      o_result = SC_OUT_WIDTH'(i_ones) >> w_k_neg;
    end else begin
      o_result = SC_OUT_WIDTH'(i_ones) << w_k;
    end
  end
`endif

endmodule

// File: rtl/sc_stream_decoder_16.sv
// sc_stream_decoder_16: receiving end of the serial stochastic-computing
// multiplier lane. Counts the ones of a unipolar bitstream over
// SC_STREAM_LENGTH valid beats, rescales the count with the two operand
// shifts and offers the 16-bit product on a valid/ready output.
//
// Optional feature: SC_DEC_SATURATE_EN selects saturation instead of
// truncation on overflow (see sc_rescale).
//
// Handshake: the result transfers on a cycle where io_out_valid and
// io_out_ready are both high; io_out_valid and io_out_data stay stable until
// then, and io_out_valid never depends on io_out_ready.
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   synchronous active-high reset
//   io_start      in   start pulse, honoured only in IDLE
//   io_a_shift    in   operand a shift, sampled with io_start
//   io_b_shift    in   operand b shift, sampled with io_start
//   io_bit_valid  in   io_bit carries a valid beat
//   io_bit        in   stochastic bit
//   io_busy       out  state != IDLE
//   io_out_valid  out  result available
//   io_out_ready  in   consumer accepts the result
//   io_out_data   out  rescaled product
//   io_out_ones   out  raw ones count (debug)
//   io_dbg_state  out  current FSM state (debug)
module sc_stream_decoder_16
  import sc_dec_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      io_start,
  input  logic [SC_SHIFT_WIDTH-1:0] io_a_shift,
  input  logic [SC_SHIFT_WIDTH-1:0] io_b_shift,
  input  logic                      io_bit_valid,
  input  logic                      io_bit,
  output logic                      io_busy,
  output logic                      io_out_valid,
  input  logic                      io_out_ready,
  output logic [SC_OUT_WIDTH-1:0]   io_out_data,
  output logic [SC_ONES_W-1:0]      io_out_ones,
  output logic [1:0]                io_dbg_state
);

  sc_dec_state_e r_state;
  sc_dec_state_e w_next;

  logic [SC_ONES_W-1:0]      r_ones;
  logic [SC_BEAT_W-1:0]      r_beat;
  logic [SC_SHIFT_WIDTH-1:0] r_sa;
  logic [SC_SHIFT_WIDTH-1:0] r_sb;
  logic [SC_OUT_WIDTH-1:0]   r_out_data;
  logic [SC_ONES_W-1:0]      r_out_ones;

  logic                      w_last_beat;
  logic [SC_OUT_WIDTH-1:0]   w_rescaled;

  assign w_last_beat = io_bit_valid && (r_beat == SC_BEAT_W'(SC_STREAM_LENGTH - 1));

  sc_rescale u_rescale (
    .i_ones   (r_ones),
    .i_sa     (r_sa),
    .i_sb     (r_sb),
    .o_result (w_rescaled)
  );

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (io_start)     w_next = ST_COUNT;
      ST_COUNT:  if (w_last_beat)  w_next = ST_SCALE;
      ST_SCALE:                    w_next = ST_OUTPUT;
      ST_OUTPUT: if (io_out_ready) w_next = ST_IDLE;
      default:                     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath registers, updated according to the current state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ones     <= '0;
      r_beat     <= '0;
      r_sa       <= '0;
      r_sb       <= '0;
      r_out_data <= '0;
      r_out_ones <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_start) begin
            r_sa   <= io_a_shift;
            r_sb   <= io_b_shift;
            r_ones <= '0;
            r_beat <= '0;
          end
        end
        ST_COUNT: begin
          if (io_bit_valid) begin
            r_ones <= r_ones + SC_ONES_W'(io_bit);
            // Power-of-two length: the last beat wraps the counter to 0.
            r_beat <= r_beat + SC_BEAT_W'(1);
          end
        end
        ST_SCALE: begin
          r_out_data <= w_rescaled;
          r_out_ones <= r_ones;
        end
        default: begin
        end
      endcase
    end
  end

  assign io_busy      = (r_state != ST_IDLE);
  assign io_out_valid = (r_state == ST_OUTPUT);
  assign io_out_data  = r_out_data;
  assign io_out_ones  = r_out_ones;
  assign io_dbg_state = r_state;

endmodule

// File: tb/tb_sc_stream_decoder_16.sv
// tb_sc_stream_decoder_16: self-checking bench for sc_stream_decoder_16.
// Table of directed operations, hand-written backpressure and reset
// sequences, then random operations checked against an arithmetic model.
module tb_sc_stream_decoder_16;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic        io_start;
  logic [2:0]  io_a_shift;
  logic [2:0]  io_b_shift;
  logic        io_bit_valid;
  logic        io_bit;
  logic        io_busy;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [15:0] io_out_data;
  logic [4:0]  io_out_ones;
  logic [1:0]  io_dbg_state;

  always #5 clock = ~clock;

  sc_stream_decoder_16 dut (
    .clock        (clock),
    .reset        (reset),
    .io_start     (io_start),
    .io_a_shift   (io_a_shift),
    .io_b_shift   (io_b_shift),
    .io_bit_valid (io_bit_valid),
    .io_bit       (io_bit),
    .io_busy      (io_busy),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_data  (io_out_data),
    .io_out_ones  (io_out_ones),
    .io_dbg_state (io_dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [4:0]  exp_ones_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: product value ones * 2^k from plain arithmetic.
  function automatic logic [15:0] model(input int ones, input int sa, input int sb);
    int     k;
    longint v;
    k = 12 - sa - sb;
    if (k >= 0) v = longint'(ones) * (longint'(1) << k);
    else        v = longint'(ones / (1 << (-k)));
`ifdef SC_DEC_SATURATE_EN
    if (v >= 65536) return 16'hFFFF;
`endif
    return 16'(v % 65536);
  endfunction

  // ---------------- driver ----------------
  // Inputs are driven and outputs sampled on the falling edge.
  task automatic run_op(input logic [2:0] sa, input logic [2:0] sb, input logic [15:0] bits,
                        input logic [15:0] gap_mask, input int ready_delay, input bit poke_start);
    logic [15:0] e_data;
    logic [4:0]  e_ones;
    @(negedge clock);
    io_start = 1'b1; io_a_shift = sa; io_b_shift = sb; io_bit_valid = 1'b0; io_bit = 1'b0;
    @(negedge clock);
    io_start = 1'b0;
    io_a_shift = 3'($urandom);
    io_b_shift = 3'($urandom);
    check("busy_in_count", io_busy, 1);
    for (int i = 0; i < 16; i++) begin
      if (gap_mask[i]) begin
        io_bit_valid = 1'b0; io_bit = 1'b1;
        @(negedge clock);
      end
      io_bit_valid = 1'b1; io_bit = bits[i];
      @(negedge clock);
    end
    io_bit_valid = 1'b0; io_bit = 1'b1;
    check("valid_low_in_scale", io_out_valid, 0);
    @(negedge clock);
    check("valid_two_after_last", io_out_valid, 1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      e_data = '0; e_ones = '0;
    end else begin
      e_data = exp_q.pop_front();
      e_ones = exp_ones_q.pop_front();
    end
    check("out_data", io_out_data, e_data);
    check("out_ones", io_out_ones, e_ones);
    for (int i = 0; i < ready_delay; i++) begin
      if (poke_start && i == 1) begin
        io_start = 1'b1; io_a_shift = 3'd0; io_b_shift = 3'd0;
      end else begin
        io_start = 1'b0;
      end
      @(negedge clock);
      check("bp_valid", io_out_valid, 1);
      check("bp_busy", io_busy, 1);
      check("bp_data", io_out_data, e_data);
    end
    io_start = 1'b0;
    io_out_ready = 1'b1;
    @(negedge clock);
    io_out_ready = 1'b0;
    check("idle_after_hs", io_busy, 0);
    check("valid_drop", io_out_valid, 0);
    if (poke_start) begin
      @(negedge clock);
      check("start_ignored", io_busy, 0);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [2:0]  sa;
    logic [2:0]  sb;
    logic [15:0] bits;
    logic [15:0] gaps;
    logic [15:0] exp_data;
    logic [4:0]  exp_ones;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [2:0]  rsa, rsb;
    logic [15:0] rbits, rgaps;

`ifdef SC_DEC_SATURATE_EN
    vecs[0] = '{3'd0, 3'd0, 16'hFFFF, 16'h0000, 16'hFFFF, 5'd16};
`else
    vecs[0] = '{3'd0, 3'd0, 16'hFFFF, 16'h0000, 16'h0000, 5'd16};
`endif
    vecs[1] = '{3'd2, 3'd3, 16'h00FF, 16'h0000, 16'h0400, 5'd8};
    vecs[2] = '{3'd7, 3'd7, 16'h0FFF, 16'h0000, 16'h0003, 5'd12};
    vecs[3] = '{3'd4, 3'd4, 16'h8431, 16'hAAAA, 16'h0050, 5'd5};
    vecs[4] = '{3'd0, 3'd0, 16'hFFFE, 16'h0000, 16'hF000, 5'd15};
    vecs[5] = '{3'd0, 3'd1, 16'hFFFF, 16'h0000, 16'h8000, 5'd16};
    vecs[6] = '{3'd6, 3'd7, 16'h7FFF, 16'h0000, 16'h0007, 5'd15};
    vecs[7] = '{3'd0, 3'd0, 16'h0100, 16'h0000, 16'h1000, 5'd1};
    vecs[8] = '{3'd3, 3'd1, 16'h0000, 16'h0000, 16'h0000, 5'd0};

    reset = 1'b1; io_start = 1'b0; io_a_shift = '0; io_b_shift = '0;
    io_bit_valid = 1'b0; io_bit = 1'b0; io_out_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", io_busy, 0);
    check("rst_valid", io_out_valid, 0);
    check("rst_data", io_out_data, 0);
    check("rst_ones", io_out_ones, 0);
    reset = 1'b0;

    for (int v = 0; v < 9; v++) begin
      exp_q.push_back(vecs[v].exp_data);
      exp_ones_q.push_back(vecs[v].exp_ones);
      run_op(vecs[v].sa, vecs[v].sb, vecs[v].bits, vecs[v].gaps, 0, 1'b0);
    end

    // Backpressure: ready low for 5 cycles with a start pulse in between.
    exp_q.push_back(16'h0400);
    exp_ones_q.push_back(5'd8);
    run_op(3'd2, 3'd3, 16'hF00F, 16'h0000, 5, 1'b1);

    // Reset on beat 9 of COUNT discards the partial count.
    @(negedge clock);
    io_start = 1'b1; io_a_shift = 3'd2; io_b_shift = 3'd2;
    @(negedge clock);
    io_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      io_bit_valid = 1'b1; io_bit = 1'b1;
      @(negedge clock);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; io_bit_valid = 1'b0;
    check("midrst_busy", io_busy, 0);
    check("midrst_valid", io_out_valid, 0);
    exp_q.push_back(16'h0000);
    exp_ones_q.push_back(5'd0);
    run_op(3'd0, 3'd0, 16'h0000, 16'h0000, 0, 1'b0);

    // Random operations against the model.
    for (int n = 0; n < 30; n++) begin
      rsa   = 3'($urandom_range(0, 7));
      rsb   = 3'($urandom_range(0, 7));
      rbits = 16'($urandom);
      rgaps = 16'($urandom) & 16'($urandom);
      exp_q.push_back(model($countones(rbits), int'(rsa), int'(rsb)));
      exp_ones_q.push_back(5'($countones(rbits)));
      run_op(rsa, rsb, rbits, rgaps, $urandom_range(0, 3), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
